// File: rtl/trace_draw_scheduler.sv
// trace_draw_scheduler: round-robin arbiter that turns per-channel scope
// samples into single-pixel frame-buffer writes, plus a full-screen clear.
module trace_draw_scheduler #(
  parameter int                      CHANNELS   = 2,
  parameter int                      Y_W        = 10,
  parameter int                      H_ACTIVE   = 1280,
  parameter int                      V_ACTIVE   = 1024,
  parameter logic [24*CHANNELS-1:0]  CH_COLOURS = 48'h00FF00_FF0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     s_valid,
  output logic [CHANNELS-1:0]     s_ready,
  input  logic [CHANNELS*Y_W-1:0] s_data,
  input  logic                    clear_req,
  input  logic                    freeze,
  output logic                    busy,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [10:0]             wr_x,
  output logic [10:0]             wr_y,
  output logic [7:0]              wr_R,
  output logic [7:0]              wr_G,
  output logic [7:0]              wr_B,
  output logic [CHANNELS-1:0]     x_wrap
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, CLEAR = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    draw_ch_q, draw_ch_d;
  logic [10:0]         xcnt_q [CHANNELS];
  logic [10:0]         xcnt_d [CHANNELS];
  logic                wr_valid_q, wr_valid_d;
  logic                busy_q, busy_d;
  logic [10:0]         wr_x_q, wr_x_d;
  logic [10:0]         wr_y_q, wr_y_d;
  logic [23:0]         wr_rgb_q, wr_rgb_d;
  logic [CHANNELS-1:0] x_wrap_q, x_wrap_d;

  logic                grant_found_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic                grant_en_s;
  logic [Y_W-1:0]      grant_sample_s;
  logic [31:0]         samp_s;
  logic [10:0]         y_map_s;

  // Round-robin search: first valid channel at or after rr_ptr, modulo CHANNELS.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!grant_found_s && s_valid[(int'(rr_ptr_q) + k) % CHANNELS]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = PTR_W'((int'(rr_ptr_q) + k) % CHANNELS);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Grant qualification, combinational s_ready and sample-to-row mapping.
  always_comb begin
    grant_en_s     = (state_q == IDLE) && !clear_req && !freeze && grant_found_s;
    grant_sample_s = s_data[int'(grant_idx_s)*Y_W +: Y_W];
    samp_s         = 32'(grant_sample_s);
    // Row 0 is the top of the screen, so larger samples draw higher up.
    if (samp_s >= 32'(V_ACTIVE)) begin
      y_map_s = 11'd0;
    end else begin
      y_map_s = 11'(32'(V_ACTIVE) - 32'd1 - samp_s);
    end
    s_ready = '0;
    if (grant_en_s) begin
      s_ready[grant_idx_s] = 1'b1;
    end else begin
      s_ready = '0;
    end
  end

  // Next-state logic for the IDLE/DRAW/CLEAR sequencer and the output register.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    draw_ch_d  = draw_ch_q;
    xcnt_d     = xcnt_q;
    wr_valid_d = wr_valid_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_rgb_d   = wr_rgb_q;
    x_wrap_d   = '0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          wr_valid_d = 1'b1;
          wr_x_d     = 11'd0;
          wr_y_d     = 11'd0;
          wr_rgb_d   = 24'h000000;
        end else if (grant_en_s) begin
          state_d    = DRAW;
          wr_valid_d = 1'b1;
          wr_x_d     = xcnt_q[grant_idx_s];
          wr_y_d     = y_map_s;
          wr_rgb_d   = CH_COLOURS[int'(grant_idx_s)*24 +: 24];
          draw_ch_d  = grant_idx_s;
          rr_ptr_d   = PTR_W'((int'(grant_idx_s) + 1) % CHANNELS);
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (wr_ready) begin
          state_d    = IDLE;
          wr_valid_d = 1'b0;
          // Column advances only once the frame buffer has taken the pixel.
          if (xcnt_q[draw_ch_q] == 11'(H_ACTIVE - 1)) begin
            xcnt_d[draw_ch_q]   = 11'd0;
            x_wrap_d[draw_ch_q] = 1'b1;
          end else begin
            xcnt_d[draw_ch_q] = xcnt_q[draw_ch_q] + 11'd1;
          end
        end else begin
          state_d = DRAW;
        end
      end
      CLEAR: begin
        if (wr_ready) begin
          if (wr_x_q == 11'(H_ACTIVE - 1)) begin
            if (wr_y_q == 11'(V_ACTIVE - 1)) begin
              // Last pixel of the sweep: traces restart from the left edge.
              state_d    = IDLE;
              wr_valid_d = 1'b0;
              for (int c = 0; c < CHANNELS; c++) begin
                xcnt_d[c] = 11'd0;
              end
            end else begin
              wr_x_d = 11'd0;
              wr_y_d = wr_y_q + 11'd1;
            end
          end else begin
            wr_x_d = wr_x_q + 11'd1;
          end
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d    = IDLE;
        wr_valid_d = 1'b0;
      end
    endcase
    busy_d = wr_valid_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      draw_ch_q  <= '0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_x_q     <= 11'd0;
      wr_y_q     <= 11'd0;
      wr_rgb_q   <= 24'h000000;
      x_wrap_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        xcnt_q[c] <= 11'd0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      draw_ch_q  <= draw_ch_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_rgb_q   <= wr_rgb_d;
      x_wrap_q   <= x_wrap_d;
      for (int c = 0; c < CHANNELS; c++) begin
        xcnt_q[c] <= xcnt_d[c];
      end
    end
  end

  assign wr_valid = wr_valid_q;
  assign busy     = busy_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_R     = wr_rgb_q[23:16];
  assign wr_G     = wr_rgb_q[15:8];
  assign wr_B     = wr_rgb_q[7:0];
  assign x_wrap   = x_wrap_q;

endmodule

// File: tb/tb_trace_draw_scheduler.sv
// Directed bench for trace_draw_scheduler on an 8x4 screen with two channels.
module tb_trace_draw_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [19:0] s_data;
  logic        clear_req;
  logic        freeze;
  logic        busy;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic [7:0]  wr_R;
  logic [7:0]  wr_G;
  logic [7:0]  wr_B;
  logic [1:0]  x_wrap;

  int checks_n = 0;
  int fail_n   = 0;

  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;

  trace_draw_scheduler #(
    .CHANNELS (2),
    .Y_W      (10),
    .H_ACTIVE (8),
    .V_ACTIVE (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .clear_req (clear_req),
    .freeze    (freeze),
    .busy      (busy),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_R      (wr_R),
    .wr_G      (wr_G),
    .wr_B      (wr_B),
    .x_wrap    (x_wrap)
  );

  // 100 MHz bench clock.
  always #5 clock = ~clock;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks_n);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic v, input int x, input int y, input logic [23:0] rgb);
    return {17'd0, v, x[10:0], y[10:0], rgb};
  endfunction

  function automatic logic [63:0] dut_pix();
    return {17'd0, wr_valid, wr_x, wr_y, wr_R, wr_G, wr_B};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    s_valid   = 2'b00;
    s_data    = 20'd0;
    clear_req = 1'b0;
    freeze    = 1'b0;
    wr_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Offer one sample on one channel, follow it through grant, DRAW and accept.
  task automatic send(input int ch, input int samp, input int ex, input int ey,
                      input logic [23:0] ergb, input logic [1:0] ewrap);
    int n;
    s_data = 20'd0;
    s_data[ch*10 +: 10] = samp[9:0];
    s_valid = 2'b00;
    s_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (s_ready[ch] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("grant", {62'd0, s_ready}, {62'd0, 2'(1 << ch)});
    tick();
    s_valid = 2'b00;
    chk("pixel", dut_pix(), pk(1'b1, ex, ey, ergb));
    chk("busy_draw", {63'd0, busy}, 64'd1);
    chk("wrap_quiet", {62'd0, x_wrap}, 64'd0);
    tick();
    chk("wrap_accept", {62'd0, x_wrap}, {62'd0, ewrap});
    chk("valid_drop", {63'd0, wr_valid}, 64'd0);
  endtask

  initial begin
    do_reset();
    // Reset state.
    chk("rst_pix", dut_pix(), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {62'd0, s_ready}, 64'd0);
    chk("rst_wrap", {62'd0, x_wrap}, 64'd0);

    // Basic mapping and x advance on ch0.
    send(0, 1, 0, 2, RED, 2'b00);
    send(0, 2, 1, 1, RED, 2'b00);
    // Run ch0 to the right edge; wrap pulses after the x=7 pixel.
    for (int i = 2; i < 8; i++) begin
      send(0, 0, i, 3, RED, (i == 7) ? 2'b01 : 2'b00);
    end
    send(0, 0, 0, 3, RED, 2'b00);

    // Round-robin alternation with both channels valid.
    do_reset();
    s_data  = {10'd0, 10'd3};
    s_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", {62'd0, s_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      chk("rr_pixel", dut_pix(), (i % 2 == 0) ? pk(1'b1, i / 2, 0, RED) : pk(1'b1, i / 2, 3, GREEN));
      chk("rr_noready", {62'd0, s_ready}, 64'd0);
      tick();
    end
    s_valid = 2'b00;

    // Back-pressure: fields hold while wr_ready is low.
    s_data  = 20'd0;
    s_valid = 2'b01;
    #1;
    chk("stall_grant", {62'd0, s_ready}, 64'd1);
    wr_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", dut_pix(), pk(1'b1, 2, 3, RED));
      chk("stall_noready", {62'd0, s_ready}, 64'd0);
      tick();
    end
    chk("stall_end", dut_pix(), pk(1'b1, 2, 3, RED));
    s_valid  = 2'b00;
    wr_ready = 1'b1;
    tick();
    chk("stall_release", {63'd0, wr_valid}, 64'd0);
    tick();
    chk("stall_single", {63'd0, wr_valid}, 64'd0);

    // Freeze blocks grants.
    freeze  = 1'b1;
    s_valid = 2'b11;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("freeze_ready", {62'd0, s_ready}, 64'd0);
      chk("freeze_valid", {63'd0, wr_valid}, 64'd0);
      tick();
    end
    freeze  = 1'b0;
    s_valid = 2'b00;
    #1;

    // Out-of-range sample clamps to the top row.
    send(1, 900, 2, 0, GREEN, 2'b00);

    // Clear beats a simultaneous sample and sweeps all 32 pixels in order.
    clear_req = 1'b1;
    s_data    = {10'd0, 10'd1};
    s_valid   = 2'b01;
    #1;
    chk("clr_noready", {62'd0, s_ready}, 64'd0);
    tick();
    clear_req = 1'b0;
    for (int n = 0; n < 32; n++) begin
      chk("clr_pixel", dut_pix(), pk(1'b1, n % 8, n / 8, 24'h000000));
      chk("clr_busy", {63'd0, busy}, 64'd1);
      chk("clr_ready", {62'd0, s_ready}, 64'd0);
      if (n == 31) begin
        s_valid = 2'b00;
      end
      tick();
    end
    chk("clr_done_valid", {63'd0, wr_valid}, 64'd0);
    chk("clr_done_busy", {63'd0, busy}, 64'd0);
    send(0, 1, 0, 2, RED, 2'b00);
    send(1, 1, 0, 2, GREEN, 2'b00);

    // Reset in the middle of a clear sweep.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (3) tick();
    chk("midclr_valid", {63'd0, wr_valid}, 64'd1);
    reset = 1'b1;
    tick();
    chk("midclr_rst_pix", dut_pix(), 64'd0);
    chk("midclr_rst_busy", {63'd0, busy}, 64'd0);
    chk("midclr_rst_wrap", {62'd0, x_wrap}, 64'd0);
    chk("midclr_rst_ready", {62'd0, s_ready}, 64'd0);
    reset = 1'b0;
    #1;
    send(0, 3, 0, 0, RED, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
